demux_collect_16: RTL and testbench
===================================

// Module: demux_collect_16
// PURPOSE
//  - Inverse of the 16:1 word selector: a 1-to-16 sequential collector. Accepts 16-bit words one per beat on a valid/ready input.
//  - Each accepted word is steered into one of 16 slot registers. The full frame is presented as a parallel 256-bit vector.
//  - Sits between a serial neuron/MAC output stream and the next autoencoder layer, which consumes 16 values in parallel.
// PARAMETERS
//  - DATA_W   16  width of one word / slot
//  - N_WORDS  16  number of slots per frame
//  - IDX_W    4   slot index width, clog2(N_WORDS)
// PORTS
//  - clk         in   1               single clock, rising edge
//  - rst_n       in   1               asynchronous, active-low reset
//  - flush       in   1               abort current frame
//  - in_valid    in   1               input word valid
//  - in_ready    out  1               collector can accept a word
//  - in_data     in   DATA_W          input word
//  - out_valid   out  1               complete frame held on out_data
//  - out_ready   in   1               consumer takes the frame
//  - out_data    out  N_WORDS*DATA_W  slot k at bits [k*DATA_W +: DATA_W]
//  - fill_count  out  IDX_W+1         words held in current frame, 0..16
// BEHAVIOUR
//  - Reset (async assert, sync release): state=FILL, idx=0, all slots=0, out_valid=0, fill_count=0.
//  - FILL state: in_ready=1, out_valid=0.
//    - Accept = in_valid & in_ready & ~flush.
//    - On accept: slot[idx] <= in_data; idx <= idx+1; fill_count <= fill_count+1.
//    - Accept at idx==N_WORDS-1 moves to HOLD next cycle: out_valid=1 the cycle after the 16th accept (latency 1). idx wraps to 0.
//  - HOLD state: in_ready=0, out_valid=1, out_data stable, fill_count=16.
//    - out_ready=1 moves to FILL next cycle with fill_count=0.
//    - No input is accepted in the handoff cycle. The earliest next accept is 1 cycle after the handshake.
//    - Slots keep their old values until overwritten.
//  - flush: next cycle state=FILL, idx=0, fill_count=0, out_valid=0. Slot contents untouched.
//    - flush wins over a simultaneous in_valid (word dropped) and over a simultaneous out_ready (frame discarded, no transfer).
//  - in_valid while in_ready=0 is ignored. The producer must hold its word.
//  - out_ready while out_valid=0 has no effect.
//  - rst_n assert mid-frame: all state and slots clear immediately. The partial frame is lost.
// CONFIGURATION
//  - `DEMUX_ADDR_EN undefined: sequential fill, as above.
//  - `DEMUX_ADDR_EN defined: extra port in_addr (in, IDX_W) selects the slot written on accept.
//    - A 16-bit written mask sets bit in_addr on each accept. fill_count = popcount(mask).
//    - Rewriting a slot overwrites the data and does not increase fill_count.
//    - HOLD is entered the cycle after the mask becomes all-ones.
//    - flush or the output handshake clears the mask.
// STRUCTURE
//  - Package autoenc_demux_pkg: DATA_W, N_WORDS, IDX_W constants; state enum {FILL, HOLD}.
//  - Sub-module demux_slot_bank: 16 x DATA_W registers with write-enable decode from index (async reset to 0).
//    - Parent holds the FSM, index counter/mask and handshake logic.
// TESTING
//  - Reset then 16 back-to-back words 0x0001..0x0010 -> out_valid rises 1 cycle after the 16th accept;
//    slot0=0x0001, slot15=0x0010; fill_count=16.
//  - out_ready held low 5 cycles in HOLD with in_valid=1 -> in_ready=0, out_data stable.
//    Then out_ready=1 -> FILL next cycle, fill_count=0.
//  - Flush after 7 words, then 16 words 0xA000..0xA00F -> frame holds 0xA000..0xA00F only; idx restarted at 0.
//  - flush and in_valid in the same cycle at fill_count=3 -> word not stored, fill_count=0.
//  - rst_n low at fill_count=9 -> out_data all zero, out_valid=0, fill_count=0 without waiting for a clock edge.
//  - `DEMUX_ADDR_EN: write slots 15 down to 0 with 0xBEEF at slot 4 written twice -> fill_count stalls on the repeat;
//    HOLD entered after slot 0; slot4 holds the last value.

Source files
------------

// File: rtl/autoenc_demux_pkg.sv
// autoenc_demux_pkg: shared widths, collector state encoding and a popcount helper
package autoenc_demux_pkg;
  localparam int DATA_W  = 16;
  localparam int N_WORDS = 16;
  localparam int IDX_W   = $clog2(N_WORDS);
  typedef enum logic {FILL, HOLD} state_t;
  function automatic logic [IDX_W:0] popcount(input logic [N_WORDS-1:0] m);
    popcount = '0;
    for (int i = 0; i < N_WORDS; i++) popcount += (IDX_W+1)'(m[i]);
  endfunction
endpackage

// File: rtl/demux_collect_16_if.sv
// demux_collect_16_if: word input stream and parallel frame output; in_addr exists only under DEMUX_ADDR_EN
interface demux_collect_16_if import autoenc_demux_pkg::*; ();
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         in_data;
`ifdef DEMUX_ADDR_EN
  logic [IDX_W-1:0]          in_addr;
`endif
  logic                      out_valid;
  logic                      out_ready;
  logic [N_WORDS*DATA_W-1:0] out_data;
  modport master (
`ifdef DEMUX_ADDR_EN
    output in_addr,
`endif
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
`ifdef DEMUX_ADDR_EN
    input  in_addr,
`endif
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_slot_bank.sv
// demux_slot_bank: N_WORDS slot registers, one written per enabled cycle at widx
module demux_slot_bank import autoenc_demux_pkg::*; (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [IDX_W-1:0]          widx,
  input  logic [DATA_W-1:0]         wdata,
  output logic [N_WORDS*DATA_W-1:0] data
);
  logic [N_WORDS-1:0][DATA_W-1:0] slot;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) slot <= '0;
    else if (we) slot[widx] <= wdata;
  assign data = slot;
endmodule

// File: rtl/demux_collect_16.sv
// demux_collect_16: 1-to-16 word collector presenting a full frame in parallel.
// Define DEMUX_ADDR_EN to steer words by in_addr with a written-slot mask instead of sequential fill.
module demux_collect_16 import autoenc_demux_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  demux_collect_16_if.slave bus,
  output logic [IDX_W:0]   fill_count
);
  state_t           state, state_nx;
  logic             acc, full, clr;
  logic [IDX_W-1:0] widx;
  assign bus.in_ready  = state == FILL;
  assign bus.out_valid = state == HOLD;
  assign acc = bus.in_valid & bus.in_ready & ~flush;
  // frame bookkeeping restarts on abort or on the output handshake
  assign clr = flush | (state == HOLD & bus.out_ready);
`ifdef DEMUX_ADDR_EN
  logic [N_WORDS-1:0] mask, mask_set;
  assign widx       = bus.in_addr;
  assign mask_set   = mask | (N_WORDS'(1) << bus.in_addr);
  assign full       = &mask_set;
  assign fill_count = popcount(mask);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mask <= '0;
    else if (clr) mask <= '0;
    else if (acc) mask <= mask_set;
`else
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   cnt;
  assign widx       = idx;
  assign full       = idx == IDX_W'(N_WORDS-1);
  assign fill_count = cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      cnt <= '0;
    end else if (clr) begin
      idx <= '0;
      cnt <= '0;
    end else if (acc) begin
      idx <= idx + 1'b1;
      cnt <= cnt + 1'b1;
    end
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FILL;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = flush ? FILL : state == FILL ? (acc & full ? HOLD : FILL) : (bus.out_ready ? FILL : HOLD);
  end
  demux_slot_bank u_bank (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (acc),
    .widx (widx),
    .wdata(bus.in_data),
    .data (bus.out_data)
  );
endmodule

// File: tb/tb_demux_collect_16.sv
// tb_demux_collect_16: directed and randomized checks against a frame-level model (DEMUX_ADDR_EN aware)
module tb_demux_collect_16;
  import autoenc_demux_pkg::*;
  logic clk = 0, rst_n = 0, flush = 0;
  logic [IDX_W:0] fill_count;
  demux_collect_16_if bus();
  demux_collect_16 dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .fill_count(fill_count));
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [DATA_W-1:0] m_slot [N_WORDS];
  bit [N_WORDS-1:0] m_wr;
  bit m_hold;
  logic [N_WORDS*DATA_W-1:0] snap;

  function automatic logic [N_WORDS*DATA_W-1:0] m_vec();
    logic [N_WORDS*DATA_W-1:0] v;
    for (int k = 0; k < N_WORDS; k++) v[k*DATA_W +: DATA_W] = m_slot[k];
    return v;
  endfunction

  task automatic model_clear();
    m_hold = 0;
    m_wr = '0;
    for (int k = 0; k < N_WORDS; k++) m_slot[k] = '0;
  endtask

  task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input int a, input bit fl, input bit ordy);
    int w;
    bus.in_valid = v;
    bus.in_data = d;
`ifdef DEMUX_ADDR_EN
    bus.in_addr = IDX_W'(a);
    w = a % N_WORDS;
`else
    w = $countones(m_wr);
`endif
    flush = fl;
    bus.out_ready = ordy;
    if (fl) begin
      m_hold = 0;
      m_wr = '0;
    end else if (m_hold) begin
      if (ordy) begin
        m_hold = 0;
        m_wr = '0;
      end
    end else if (v) begin
      m_slot[w] = d;
      m_wr[w] = 1;
      if (&m_wr) m_hold = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 0;
    bus.in_data = '0;
`ifdef DEMUX_ADDR_EN
    bus.in_addr = '0;
`endif
    bus.out_ready = 0;
    flush = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (fill_count !== 0) begin failures++; $display("FAIL reset_fill_count got=%0d exp=0", fill_count); end
    checks++; if (bus.out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
  endtask

  task automatic test_seq_fill();
    for (int i = 0; i < N_WORDS; i++) begin
      cycle(1, DATA_W'(i + 1), i, 0, 0);
      if (i == N_WORDS - 2) begin
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL fill_early_valid got=%b exp=0", bus.out_valid); end
      end
    end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL fill_out_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_data[0 +: DATA_W] !== 16'h0001) begin failures++; $display("FAIL fill_slot0 got=%h exp=0001", bus.out_data[0 +: DATA_W]); end
    checks++; if (bus.out_data[15*DATA_W +: DATA_W] !== 16'h0010) begin failures++; $display("FAIL fill_slot15 got=%h exp=0010", bus.out_data[15*DATA_W +: DATA_W]); end
    checks++; if (fill_count !== 16) begin failures++; $display("FAIL fill_count16 got=%0d exp=16", fill_count); end
    checks++; if (bus.out_data !== m_vec()) begin failures++; $display("FAIL fill_frame got=%h exp=%h", bus.out_data, m_vec()); end
  endtask

  task automatic test_hold_stall();
    snap = m_vec();
    repeat (5) begin
      cycle(1, DATA_W'($urandom), 0, 0, 0);
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready got=%b exp=0", bus.in_ready); end
      checks++; if (bus.out_data !== snap) begin failures++; $display("FAIL hold_stable got=%h exp=%h", bus.out_data, snap); end
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL hold_valid got=%b exp=1", bus.out_valid); end
    end
    cycle(0, '0, 0, 0, 1);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL handoff_valid got=%b exp=0", bus.out_valid); end
    checks++; if (fill_count !== 0) begin failures++; $display("FAIL handoff_count got=%0d exp=0", fill_count); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL handoff_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 7; i++) cycle(1, DATA_W'($urandom), i, 0, 0);
    cycle(0, '0, 0, 1, 0);
    checks++; if (fill_count !== 0) begin failures++; $display("FAIL flush_count got=%0d exp=0", fill_count); end
    for (int i = 0; i < N_WORDS; i++) cycle(1, DATA_W'(16'hA000 + i), i, 0, 0);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL flush_refill_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_data[0 +: DATA_W] !== 16'hA000) begin failures++; $display("FAIL flush_slot0 got=%h exp=a000", bus.out_data[0 +: DATA_W]); end
    checks++; if (bus.out_data[15*DATA_W +: DATA_W] !== 16'hA00F) begin failures++; $display("FAIL flush_slot15 got=%h exp=a00f", bus.out_data[15*DATA_W +: DATA_W]); end
    checks++; if (bus.out_data !== m_vec()) begin failures++; $display("FAIL flush_frame got=%h exp=%h", bus.out_data, m_vec()); end
    cycle(0, '0, 0, 0, 1);
  endtask

  task automatic test_flush_collide();
    for (int i = 0; i < 3; i++) cycle(1, DATA_W'($urandom), i, 0, 0);
    checks++; if (fill_count !== 3) begin failures++; $display("FAIL collide_pre_count got=%0d exp=3", fill_count); end
    cycle(1, 16'hDEAD, 3, 1, 0);
    checks++; if (fill_count !== 0) begin failures++; $display("FAIL collide_count got=%0d exp=0", fill_count); end
    checks++; if (bus.out_data !== m_vec()) begin failures++; $display("FAIL collide_slots got=%h exp=%h", bus.out_data, m_vec()); end
    cycle(1, 16'h5555, 0, 0, 0);
    checks++; if (bus.out_data[0 +: DATA_W] !== 16'h5555) begin failures++; $display("FAIL collide_restart got=%h exp=5555", bus.out_data[0 +: DATA_W]); end
    checks++; if (fill_count !== 1) begin failures++; $display("FAIL collide_next_count got=%0d exp=1", fill_count); end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i < 9; i++) cycle(1, DATA_W'($urandom | 1), i, 0, 0);
    checks++; if (fill_count !== 9) begin failures++; $display("FAIL areset_pre_count got=%0d exp=9", fill_count); end
    idle();
    #2 rst_n = 0;
    #1;
    checks++; if (bus.out_data !== '0) begin failures++; $display("FAIL areset_data got=%h exp=0", bus.out_data); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (fill_count !== 0) begin failures++; $display("FAIL areset_count got=%0d exp=0", fill_count); end
    model_clear();
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3) != 0, DATA_W'($urandom), int'($urandom_range(0, N_WORDS - 1)),
            $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
      checks++; if (bus.out_valid !== m_hold) begin failures++; $display("FAIL rand_valid n=%0d got=%b exp=%b", n, bus.out_valid, m_hold); end
      checks++; if (bus.in_ready !== !m_hold) begin failures++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, bus.in_ready, !m_hold); end
      checks++; if (fill_count !== $countones(m_wr)) begin failures++; $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, fill_count, $countones(m_wr)); end
      checks++; if (bus.out_data !== m_vec()) begin failures++; $display("FAIL rand_data n=%0d got=%h exp=%h", n, bus.out_data, m_vec()); end
    end
  endtask

`ifdef DEMUX_ADDR_EN
  task automatic test_addr();
    cycle(0, '0, 0, 1, 0);
    for (int s = 15; s >= 5; s--) cycle(1, DATA_W'(16'hC000 + s), s, 0, 0);
    cycle(1, 16'h1111, 4, 0, 0);
    checks++; if (fill_count !== 12) begin failures++; $display("FAIL addr_first4 got=%0d exp=12", fill_count); end
    cycle(1, 16'hBEEF, 4, 0, 0);
    checks++; if (fill_count !== 12) begin failures++; $display("FAIL addr_repeat4 got=%0d exp=12", fill_count); end
    for (int s = 3; s >= 0; s--) begin
      cycle(1, DATA_W'(16'hC000 + s), s, 0, 0);
      if (s == 1) begin
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL addr_early_valid got=%b exp=0", bus.out_valid); end
      end
    end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL addr_valid got=%b exp=1", bus.out_valid); end
    checks++; if (fill_count !== 16) begin failures++; $display("FAIL addr_count got=%0d exp=16", fill_count); end
    checks++; if (bus.out_data[4*DATA_W +: DATA_W] !== 16'hBEEF) begin failures++; $display("FAIL addr_slot4 got=%h exp=beef", bus.out_data[4*DATA_W +: DATA_W]); end
    checks++; if (bus.out_data !== m_vec()) begin failures++; $display("FAIL addr_frame got=%h exp=%h", bus.out_data, m_vec()); end
    cycle(0, '0, 0, 0, 1);
  endtask
`endif

  initial begin
    test_reset();
    test_seq_fill();
    test_hold_stall();
    test_flush();
    test_flush_collide();
    test_async_reset();
    test_random();
`ifdef DEMUX_ADDR_EN
    test_addr();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
